divider_repeated_sub: RTL

//   Unsigned integer divider using repeated subtraction; inverse companion of the repeated-addition multiplier.

---
 rtl/div_pkg.sv | 6 +
 rtl/divider_control_path.sv | 61 ++++++
 rtl/divider_data_path.sv | 33 +++
 rtl/divider_repeated_sub.sv | 32 +++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the repeated-subtraction divider
package div_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} state_t;
endpackage

// File: rtl/divider_control_path.sv
// divider_control_path: FSM sequencing operand loads and subtraction steps; DIVZ_FLAG_EN adds the divide-by-zero flag
module divider_control_path
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ge,
  input  logic bz,
  output logic load_a,
  output logic load_b,
  output logic clear_q,
  output logic sub_en,
  output logic sat_q,
`ifdef DIVZ_FLAG_EN
  output logic div_by_zero,
`endif
  output logic done
);
  state_t state, state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == LOAD_A ? 1'b0 : (state == CALC && state_n == DONE) ? 1'b1 : done;
    end
`ifdef DIVZ_FLAG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) div_by_zero <= 1'b0;
    else div_by_zero <= state == LOAD_A ? 1'b0 : (state == CALC && bz) ? 1'b1 : div_by_zero;
`endif
  always_comb begin
    state_n = state;
    load_a = 1'b0;
    load_b = 1'b0;
    clear_q = 1'b0;
    sub_en = 1'b0;
    sat_q = 1'b0;
    case (state)
      IDLE, DONE: state_n = start ? LOAD_A : state;
      LOAD_A: begin
        load_a = 1'b1;
        clear_q = 1'b1;
        state_n = LOAD_B;
      end
      LOAD_B: begin
        load_b = 1'b1;
        state_n = CALC;
      end
      CALC: begin
        // a zero divisor saturates the quotient instead of looping forever
        sat_q = bz;
        sub_en = !bz && ge;
        state_n = (bz || !ge) ? DONE : CALC;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/divider_data_path.sv
// divider_data_path: remainder, divisor and quotient registers with subtract/compare logic
module divider_data_path
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             clear_q,
  input  logic             sub_en,
  input  logic             sat_q,
  output logic             ge,
  output logic             bz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] b;
  assign ge = remainder >= b;
  assign bz = b == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      remainder <= '0;
      quotient <= '0;
      b <= '0;
    end else begin
      remainder <= load_a ? data_in : sub_en ? remainder - b : remainder;
      quotient <= clear_q ? '0 : sub_en ? quotient + 1'b1 : sat_q ? '1 : quotient;
      b <= load_b ? data_in : b;
    end
endmodule

// File: rtl/divider_repeated_sub.sv
// divider_repeated_sub: serial-operand unsigned divider by repeated subtraction; DIVZ_FLAG_EN adds div_by_zero
module divider_repeated_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
`ifdef DIVZ_FLAG_EN
  output logic             div_by_zero,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic load_a, load_b, clear_q, sub_en, sat_q, ge, bz;
  divider_control_path u_ctrl (
    .clk(clk), .rst(rst), .start(start), .ge(ge), .bz(bz),
    .load_a(load_a), .load_b(load_b), .clear_q(clear_q), .sub_en(sub_en), .sat_q(sat_q),
`ifdef DIVZ_FLAG_EN
    .div_by_zero(div_by_zero),
`endif
    .done(done)
  );
  divider_data_path #(.WIDTH(WIDTH)) u_data (
    .clk(clk), .rst(rst), .data_in(data_in),
    .load_a(load_a), .load_b(load_b), .clear_q(clear_q), .sub_en(sub_en), .sat_q(sat_q),
    .ge(ge), .bz(bz), .quotient(quotient), .remainder(remainder)
  );
endmodule
